exe_stage_muldiv: RTL and testbench
===================================

Name: exe_stage_muldiv

Overview:
- Execute stage that consumes the ID/EX pipeline register outputs and drives the EX/MEM boundary with registered results.
- Single-cycle ALU ops complete in 1 cycle.
- MUL/DIV/REM run on an iterative 32-step engine and raise exe_stall, so ID/EX and IF/ID hold until the result issues.
- A hazard bubble (all-zero control from ID/EX) passes through as a bubble.

Parameters:
- WIDTH, 32, datapath width; also the iteration count of the mul/div engine.
- CMD_W, 5, EXE_CMD width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- PC_in  in  32  PC of the instruction in ID/EX
- Dest_in  in  5  destination register
- Reg2_in  in  32  store data
- Val1_in  in  32  operand A
- Val2_in  in  32  operand B / sign-extended immediate
- EXE_CMD_in  in  5  operation code
- Br_taken_in  in  1  branch resolved taken in ID
- MEM_R_EN_in  in  1  load
- MEM_W_EN_in  in  1  store
- WB_EN_in  in  1  register writeback
- ALU_result  out  32  registered result
- ST_val  out  32  registered store data
- Br_addr  out  32  registered PC_in + (Val2_in << 2)
- Dest  out  5  registered destination register
- Br_taken  out  1  registered
- MEM_R_EN  out  1  registered
- MEM_W_EN  out  1  registered
- WB_EN  out  1  registered
- exe_stall  out  1  combinational; holds ID/EX and earlier stages

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE, iteration count=0.
  - All outputs 0; exe_stall=0 while rst is high.
  - Any partial mul/div result is discarded.
- EXE_CMD encoding:
  - 0 ADD, 1 SUB (Val1-Val2), 2 AND, 3 OR, 4 NOR, 5 XOR.
  - 6 SLL, 7 SRL, 8 SRA; shift amount is Val2[4:0].
  - 9 MUL (low 32 bits of product), 10 DIVU (quotient), 11 REMU (remainder).
  - Any other code: ALU_result=0, control fields pass through.
- All arithmetic is modulo 2^32; no overflow flag.
- Single-cycle op in IDLE: every output register loads on the next edge (latency 1); exe_stall=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE with EXE_CMD_in in {9,10,11}:
  - exe_stall=1 combinationally.
  - At the edge: latch operands and the op, count<=0, go to BUSY.
  - Output registers load a bubble: WB_EN, MEM_R_EN, MEM_W_EN and Br_taken = 0; data fields = 0.
- BUSY:
  - exe_stall=1.
  - Output registers hold the bubble.
  - One shift-add (MUL) or restoring-subtract (DIV/REM) step per cycle.
  - At count==WIDTH-1, go to DONE; otherwise count++.
- DONE:
  - exe_stall=0.
  - At the edge, the output registers load the engine result plus the control fields still held on the ID/EX inputs; go to IDLE.
- Timing: MUL seen in cycle t stalls cycles t..t+32 (33 cycles) and has its result visible from cycle t+34.
- Back-to-back mul/div: the next op enters from IDLE normally.
- Divide by zero (Val2==0): quotient=32'hFFFFFFFF, remainder=Val1. The full 32 iterations still run, so latency is unchanged.
- DIV/REM are unsigned. MUL result is sign-agnostic (low word).
- Inputs are sampled only in IDLE. While BUSY, changes on the inputs are ignored for the operands; the control fields are taken in DONE.
- Bubble handling: all-zero control inputs produce all-zero control outputs. EXE_CMD 0 with WB_EN=0 is harmless.
- Br_addr and ST_val are computed from the current inputs in every loading cycle. During BUSY they hold 0 (bubble).

Decomposition:
- Shared package holds:
  - EXE_CMD localparams (ADD..REMU).
  - The state enum (IDLE/BUSY/DONE).
  - WIDTH default.
- One sub-module, muldiv_iter:
  - Inputs: start, op, a, b.
  - Outputs: busy, done, result.
  - Contains the counter and shift registers.
  - exe_stage_muldiv wraps it together with the ALU and the output registers.

Test Plan:
- Reset mid-op: MUL 7*6 issued, rst pulsed at BUSY cycle 10 -> all outputs 0, exe_stall 0; a following ADD 3+4 gives ALU_result=7 one cycle after rst falls.
- ALU sweep: Val1=0xF0F0F0F0, Val2=0x0000000F, cmds 0..8 -> each of ADD/SUB/AND/OR/NOR/XOR/SLL/SRL/SRA registered 1 cycle later and matching the golden model; SRA of 0x80000000 by 4 -> 0xF8000000.
- MUL: Val1=0xFFFFFFFF, Val2=3, WB_EN=1, Dest=5 -> exe_stall high exactly 33 cycles; ALU_result=0xFFFFFFFD, Dest=5, WB_EN=1 for exactly one cycle; WB_EN=0 throughout the stall.
- DIVU/REMU: 100/7 -> 14 and 2. Divide by zero with Val1=0x1234 -> DIVU=0xFFFFFFFF, REMU=0x1234, same 33-cycle stall.
- Back-to-back DIVU then ADD held by stall -> ADD result appears exactly one cycle after the DIVU result, no duplicate DIVU issue.
- Bubble plus branch: all-zero inputs -> all-zero outputs; PC_in=0x100, Val2=0xFFFFFFFE, Br_taken_in=1 -> Br_addr=0x000000F8, Br_taken=1.

Source files
------------

// File: rtl/exe_stage_muldiv_pkg.sv
// exe_stage_muldiv_pkg: shared op codes, FSM states and default width for the execute stage.
package exe_stage_muldiv_pkg;
    localparam int WIDTH_DEF = 32;
    localparam logic [4:0] CMD_ADD  = 5'd0;
    localparam logic [4:0] CMD_SUB  = 5'd1;
    localparam logic [4:0] CMD_AND  = 5'd2;
    localparam logic [4:0] CMD_OR   = 5'd3;
    localparam logic [4:0] CMD_NOR  = 5'd4;
    localparam logic [4:0] CMD_XOR  = 5'd5;
    localparam logic [4:0] CMD_SLL  = 5'd6;
    localparam logic [4:0] CMD_SRL  = 5'd7;
    localparam logic [4:0] CMD_SRA  = 5'd8;
    localparam logic [4:0] CMD_MUL  = 5'd9;
    localparam logic [4:0] CMD_DIVU = 5'd10;
    localparam logic [4:0] CMD_REMU = 5'd11;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/exe_stage_muldiv_muldiv_iter.sv
// muldiv_iter: one-bit-per-cycle shift-add multiplier and restoring divider sharing one FSM.
module muldiv_iter
    import exe_stage_muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [4:0] op_q;
    logic [WIDTH-1:0] r, q, m, d;
    logic [WIDTH:0] t;
    logic ge;
    // r is the product accumulator or partial remainder; q the multiplier or dividend/quotient
    always_comb begin
        t = {r, q[WIDTH-1]};
        ge = t >= {1'b0, d};
        state_n = state == IDLE ? (start ? BUSY : IDLE) :
                  state == BUSY ? (cnt == LAST ? DONE : BUSY) : IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            op_q <= '0;
            r <= '0;
            q <= '0;
            m <= '0;
            d <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                op_q <= op;
                cnt <= '0;
                r <= '0;
                q <= op == CMD_MUL ? b : a;
                m <= a;
                d <= b;
            end else if (state == BUSY) begin
                cnt <= cnt + 1'b1;
                if (op_q == CMD_MUL) begin
                    r <= r + (q[0] ? m : '0);
                    q <= q >> 1;
                    m <= m << 1;
                end else begin
                    r <= ge ? WIDTH'(t - {1'b0, d}) : t[WIDTH-1:0];
                    q <= {q[WIDTH-2:0], ge};
                end
            end
        end
    end
    assign busy = state == BUSY;
    assign done = state == DONE;
    assign result = op_q == CMD_DIVU ? q : r;
endmodule

// File: rtl/exe_stage_muldiv.sv
// exe_stage_muldiv: execute stage with single-cycle ALU and iterative mul/div, registering the EX/MEM boundary.
module exe_stage_muldiv
    import exe_stage_muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CMD_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] PC_in,
    input  logic [4:0]       Dest_in,
    input  logic [WIDTH-1:0] Reg2_in,
    input  logic [WIDTH-1:0] Val1_in,
    input  logic [WIDTH-1:0] Val2_in,
    input  logic [CMD_W-1:0] EXE_CMD_in,
    input  logic             Br_taken_in,
    input  logic             MEM_R_EN_in,
    input  logic             MEM_W_EN_in,
    input  logic             WB_EN_in,
    output logic [WIDTH-1:0] ALU_result,
    output logic [WIDTH-1:0] ST_val,
    output logic [WIDTH-1:0] Br_addr,
    output logic [4:0]       Dest,
    output logic             Br_taken,
    output logic             MEM_R_EN,
    output logic             MEM_W_EN,
    output logic             WB_EN,
    output logic             exe_stall
);
    logic busy, done, is_md, start, bubble;
    logic [4:0] cmd, sh;
    logic [WIDTH-1:0] alu, md_res, res;
    assign cmd = 5'(EXE_CMD_in);
    assign sh = Val2_in[4:0];
    assign is_md = cmd == CMD_MUL || cmd == CMD_DIVU || cmd == CMD_REMU;
    assign start = !busy && !done && is_md;
    assign bubble = busy || start;
    assign exe_stall = !rst && bubble;
    muldiv_iter #(.WIDTH(WIDTH)) u_md (
        .clk(clk), .rst(rst), .start(start), .op(cmd), .a(Val1_in), .b(Val2_in),
        .busy(busy), .done(done), .result(md_res)
    );
    always_comb begin
        alu = cmd == CMD_ADD ? Val1_in + Val2_in :
              cmd == CMD_SUB ? Val1_in - Val2_in :
              cmd == CMD_AND ? Val1_in & Val2_in :
              cmd == CMD_OR  ? Val1_in | Val2_in :
              cmd == CMD_NOR ? ~(Val1_in | Val2_in) :
              cmd == CMD_XOR ? Val1_in ^ Val2_in :
              cmd == CMD_SLL ? Val1_in << sh :
              cmd == CMD_SRL ? Val1_in >> sh :
              cmd == CMD_SRA ? WIDTH'($signed(Val1_in) >>> sh) : '0;
        res = done ? md_res : alu;
    end
    // while an op is entering or iterating, the boundary carries a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst || bubble) begin
            ALU_result <= '0;
            ST_val <= '0;
            Br_addr <= '0;
            Dest <= '0;
            Br_taken <= 1'b0;
            MEM_R_EN <= 1'b0;
            MEM_W_EN <= 1'b0;
            WB_EN <= 1'b0;
        end else begin
            ALU_result <= res;
            ST_val <= Reg2_in;
            Br_addr <= PC_in + (Val2_in << 2);
            Dest <= Dest_in;
            Br_taken <= Br_taken_in;
            MEM_R_EN <= MEM_R_EN_in;
            MEM_W_EN <= MEM_W_EN_in;
            WB_EN <= WB_EN_in;
        end
    end
endmodule

// File: tb/tb_exe_stage_muldiv.sv
// tb_exe_stage_muldiv: directed vector table for the ALU plus hand-written mul/div, reset and bubble sequences.
module tb_exe_stage_muldiv;
    logic clk = 1'b0, rst = 1'b1;
    logic [31:0] PC_in, Reg2_in, Val1_in, Val2_in;
    logic [4:0] Dest_in, EXE_CMD_in;
    logic Br_taken_in, MEM_R_EN_in, MEM_W_EN_in, WB_EN_in;
    logic [31:0] ALU_result, ST_val, Br_addr;
    logic [4:0] Dest;
    logic Br_taken, MEM_R_EN, MEM_W_EN, WB_EN, exe_stall;
    int tests = 0, fails = 0;

    exe_stage_muldiv dut (
        .clk(clk), .rst(rst), .PC_in(PC_in), .Dest_in(Dest_in), .Reg2_in(Reg2_in),
        .Val1_in(Val1_in), .Val2_in(Val2_in), .EXE_CMD_in(EXE_CMD_in),
        .Br_taken_in(Br_taken_in), .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in),
        .WB_EN_in(WB_EN_in), .ALU_result(ALU_result), .ST_val(ST_val), .Br_addr(Br_addr),
        .Dest(Dest), .Br_taken(Br_taken), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
        .WB_EN(WB_EN), .exe_stall(exe_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] cmd;
        logic [31:0] v1, v2, exp;
    } vec_t;
    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] cmd, input logic [31:0] v1, input logic [31:0] v2,
                         input logic [4:0] dst, input logic wb);
        EXE_CMD_in = cmd; Val1_in = v1; Val2_in = v2; Dest_in = dst; WB_EN_in = wb;
        PC_in = 0; Reg2_in = 0; Br_taken_in = 0; MEM_R_EN_in = 0; MEM_W_EN_in = 0;
    endtask

    // issues a mul/div op and holds it like a stalled ID/EX; leaves time at the result cycle
    task automatic run_md(input string name, input logic [4:0] cmd, input logic [31:0] v1,
                          input logic [31:0] v2, input logic [31:0] exp);
        int n, wb_bad;
        n = 0; wb_bad = 0;
        drive(cmd, v1, v2, 5'd5, 1'b1);
        for (int i = 0; i < 100; i++) begin
            #1;
            if (!exe_stall) break;
            n++;
            if (i > 0 && WB_EN) wb_bad++;
            @(posedge clk); #1;
        end
        chk({name, " stall_cycles"}, n, 33);
        chk({name, " wb_during_stall"}, wb_bad, 0);
        @(posedge clk); #1;
        chk({name, " result"}, ALU_result, exp);
        chk({name, " dest"}, {27'd0, Dest}, 32'd5);
        chk({name, " wb"}, {31'd0, WB_EN}, 32'd1);
    endtask

    initial begin
        vecs[0]  = '{5'd0,  32'hF0F0F0F0, 32'h0000000F, 32'hF0F0F0FF};
        vecs[1]  = '{5'd1,  32'hF0F0F0F0, 32'h0000000F, 32'hF0F0F0E1};
        vecs[2]  = '{5'd2,  32'hF0F0F0F0, 32'h0000000F, 32'h00000000};
        vecs[3]  = '{5'd3,  32'hF0F0F0F0, 32'h0000000F, 32'hF0F0F0FF};
        vecs[4]  = '{5'd4,  32'hF0F0F0F0, 32'h0000000F, 32'h0F0F0F00};
        vecs[5]  = '{5'd5,  32'hF0F0F0F0, 32'h0000000F, 32'hF0F0F0FF};
        vecs[6]  = '{5'd6,  32'hF0F0F0F0, 32'h0000000F, 32'h78780000};
        vecs[7]  = '{5'd7,  32'hF0F0F0F0, 32'h0000000F, 32'h0001E1E1};
        vecs[8]  = '{5'd8,  32'hF0F0F0F0, 32'h0000000F, 32'hFFFFE1E1};
        vecs[9]  = '{5'd8,  32'h80000000, 32'h00000004, 32'hF8000000};
        vecs[10] = '{5'd6,  32'h00000001, 32'h00000021, 32'h00000002};
        vecs[11] = '{5'd12, 32'h12345678, 32'h00000003, 32'h00000000};

        drive(5'd0, 0, 0, 0, 0);
        #12;
        chk("reset_result", ALU_result, 0);
        chk("reset_stall", {31'd0, exe_stall}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].cmd, vecs[i].v1, vecs[i].v2, 5'd3, 1'b1);
            @(posedge clk); #1;
            chk($sformatf("alu_vec%0d", i), ALU_result, vecs[i].exp);
        end
        chk("alu_dest", {27'd0, Dest}, 32'd3);

        run_md("mul", 5'd9, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD);
        drive(5'd0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("mul_wb_one_cycle", {31'd0, WB_EN}, 0);

        run_md("divu", 5'd10, 32'd100, 32'd7, 32'd14);
        run_md("remu", 5'd11, 32'd100, 32'd7, 32'd2);
        run_md("divu0", 5'd10, 32'h1234, 32'd0, 32'hFFFFFFFF);
        run_md("remu0", 5'd11, 32'h1234, 32'd0, 32'h1234);

        // back-to-back: ADD enters as soon as the DIVU result issues
        run_md("b2b_divu", 5'd10, 32'd50, 32'd5, 32'd10);
        drive(5'd0, 32'd20, 32'd22, 5'd7, 1'b1);
        #1;
        chk("b2b_no_reissue", {31'd0, exe_stall}, 0);
        @(posedge clk); #1;
        chk("b2b_add", ALU_result, 32'd42);
        chk("b2b_add_dest", {27'd0, Dest}, 32'd7);

        // reset in the middle of an iteration
        drive(5'd9, 32'd7, 32'd6, 5'd4, 1'b1);
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        chk("rst_mid_stall", {31'd0, exe_stall}, 0);
        chk("rst_mid_result", ALU_result, 0);
        chk("rst_mid_wb", {31'd0, WB_EN}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(5'd0, 32'd3, 32'd4, 5'd2, 1'b1);
        #1;
        chk("rst_add_stall", {31'd0, exe_stall}, 0);
        @(posedge clk); #1;
        chk("rst_add_result", ALU_result, 32'd7);

        drive(5'd0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("bubble_ctrl", {27'd0, Dest, Br_taken, MEM_R_EN, MEM_W_EN, WB_EN}, 0);
        chk("bubble_data", ALU_result | ST_val | Br_addr, 0);
        drive(5'd0, 0, 32'hFFFFFFFE, 0, 0);
        PC_in = 32'h100; Br_taken_in = 1'b1; Reg2_in = 32'hCAFE; MEM_W_EN_in = 1'b1;
        @(posedge clk); #1;
        chk("br_addr", Br_addr, 32'h000000F8);
        chk("br_taken", {31'd0, Br_taken}, 1);
        chk("st_val", ST_val, 32'hCAFE);
        chk("mem_w_en", {31'd0, MEM_W_EN}, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
